// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, imem request/ack handshake, one registered output
// slot with a one-entry skid buffer, and flush/refetch on branch redirect.
//
// state | meaning
// ------+-----------------------------------------------------------------
// START | first cycle after reset, no request yet
// FETCH | request at req_addr_q is on the bus
// FULL  | output slot and skid both hold instructions, request paused
// KILL  | wrong-path request still awaiting ack; data will be dropped
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus4
);

    typedef enum logic [1:0] {
        START = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2,
        KILL  = 2'd3
    } state_t;

    state_t      state_q;
    logic        req_q;
    logic [31:0] req_addr_q;
    logic [31:0] pend_pc_q;
    logic [31:0] skid_instr_q;
    logic [31:0] skid_pc_q;
    logic        skid_valid_q;
    logic [31:0] instr_q;
    logic        instr_valid_q;
    logic [31:0] instr_pc_q;
    logic [31:0] pc_plus4_q;

    logic [31:0] redirect_tgt;
    logic        slot_free;
    logic [31:0] req_addr_inc;

    assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
    assign slot_free    = !instr_valid_q || !stall;
    assign req_addr_inc = req_addr_q + 32'd4;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= START;
            req_q         <= 1'b0;
            req_addr_q    <= RESET_PC;
            pend_pc_q     <= 32'd0;
            skid_instr_q  <= NOP;
            skid_pc_q     <= 32'd0;
            skid_valid_q  <= 1'b0;
            instr_q       <= NOP;
            instr_valid_q <= 1'b0;
            instr_pc_q    <= 32'd0;
            pc_plus4_q    <= 32'd0;
        end else if (redirect) begin
            instr_q       <= NOP;
            instr_valid_q <= 1'b0;
            skid_valid_q  <= 1'b0;
            req_q         <= 1'b1;
            // An unacked request must stay on the bus; its data gets dropped in KILL.
            if (req_q && !imem_ack) begin
                pend_pc_q <= redirect_tgt;
                state_q   <= KILL;
            end else begin
                req_addr_q <= redirect_tgt;
                state_q    <= FETCH;
            end
        end else begin
            case (state_q)
                START: begin
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack) begin
                        req_addr_q <= req_addr_inc;
                        if (slot_free) begin
                            instr_q       <= imem_rdata;
                            instr_pc_q    <= req_addr_q;
                            pc_plus4_q    <= req_addr_inc;
                            instr_valid_q <= 1'b1;
                        end else begin
                            skid_instr_q <= imem_rdata;
                            skid_pc_q    <= req_addr_q;
                            skid_valid_q <= 1'b1;
                            state_q      <= FULL;
                            req_q        <= 1'b0;
                        end
                    end else if (slot_free && instr_valid_q) begin
                        instr_q       <= NOP;
                        instr_valid_q <= 1'b0;
                    end
                end
                FULL: begin
                    if (!stall) begin
                        instr_q       <= skid_instr_q;
                        instr_pc_q    <= skid_pc_q;
                        pc_plus4_q    <= skid_pc_q + 32'd4;
                        instr_valid_q <= skid_valid_q;
                        skid_valid_q  <= 1'b0;
                        state_q       <= FETCH;
                        req_q         <= 1'b1;
                    end
                end
                KILL: begin
                    if (imem_ack) begin
                        req_addr_q <= pend_pc_q;
                        state_q    <= FETCH;
                    end
                end
                default: begin
                    state_q <= START;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = req_addr_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign instr_pc    = instr_pc_q;
    assign pc_plus4    = pc_plus4_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: a program-order queue model predicts the
// request stream and the instruction slot contents every cycle.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    logic        clk;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;

    instr_fetch #(.RESET_PC(RESET_PC), .NOP(NOP)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_pc    (instr_pc),
        .pc_plus4    (pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: instructions delivered but not yet consumed, in order.
    logic [31:0] qa[$];
    logic [31:0] qd[$];
    logic [31:0] exp_next;
    logic [31:0] held_addr;
    logic        kill;
    logic        m_start;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        qa.delete();
        qd.delete();
        exp_next  = RESET_PC;
        held_addr = RESET_PC;
        kill      = 1'b0;
        m_start   = 1'b1;
    endtask

    function automatic logic model_req();
        return !m_start && (qa.size() < 2);
    endfunction

    task automatic model_step();
        logic        m_req;
        logic [31:0] cur_addr;
        m_req    = model_req();
        cur_addr = kill ? held_addr : exp_next;
        if (redirect) begin
            qa.delete();
            qd.delete();
            if (m_req && !imem_ack) begin
                if (!kill) held_addr = cur_addr;
                kill = 1'b1;
            end else begin
                kill = 1'b0;
            end
            exp_next = {redirect_pc[31:2], 2'b00};
        end else if (kill) begin
            if (imem_ack) kill = 1'b0;
        end else begin
            if (qa.size() > 0 && !stall) begin
                void'(qa.pop_front());
                void'(qd.pop_front());
            end
            if (m_req && imem_ack) begin
                qa.push_back(exp_next);
                qd.push_back(imem_rdata);
                exp_next = exp_next + 32'd4;
            end
        end
        m_start = 1'b0;
    endtask

    task automatic check_outputs();
        logic exp_req;
        exp_req = model_req();
        chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        if (exp_req) chk("imem_addr", imem_addr, kill ? held_addr : exp_next);
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, (qa.size() > 0)});
        if (qa.size() > 0) begin
            chk("instr", instr, qd[0]);
            chk("instr_pc", instr_pc, qa[0]);
            chk("pc_plus4", pc_plus4, qa[0] + 32'd4);
        end else begin
            chk("instr_nop", instr, NOP);
        end
    endtask

    task automatic drive(input int cyc);
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        if (cyc < 30) begin
            imem_ack = 1'b1;
            stall    = 1'b0;
        end else if (cyc < 60) begin
            imem_ack = 1'b1;
            stall    = ($urandom_range(0, 1) == 1);
        end else if (cyc < 100) begin
            imem_ack = (cyc % 3 == 0);
            stall    = 1'b0;
            if (cyc == 70) begin
                redirect    = 1'b1;
                redirect_pc = 32'h0040_0100;
            end
        end else if (cyc < 140) begin
            imem_ack = 1'b1;
            stall    = 1'b0;
            if (cyc == 100) begin
                redirect    = 1'b1;
                redirect_pc = 32'h0040_0203;
            end else if (cyc == 120) begin
                redirect    = 1'b1;
                redirect_pc = 32'hFFFF_FFFC;
            end
        end else begin
            imem_ack = ($urandom_range(0, 9) < 6);
            stall    = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 9) == 0) begin
                redirect    = 1'b1;
                redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                          : 32'($urandom());
            end
        end
        imem_rdata = (cyc < 60) ? imem_addr + 32'd1 : 32'($urandom());
    endtask

    task automatic do_reset();
        imem_ack = 1'b0;
        stall    = 1'b0;
        redirect = 1'b0;
        reset_n  = 1'b0;
        #1;
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, NOP);
        chk("rst_imem_addr", imem_addr, RESET_PC);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n     = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'd0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        model_reset();
        repeat (2) begin
            @(negedge clk);
            chk("reset_req", {31'd0, imem_req}, 32'd0);
            chk("reset_addr", imem_addr, RESET_PC);
            chk("reset_instr", instr, NOP);
            chk("reset_valid", {31'd0, instr_valid}, 32'd0);
            chk("reset_pc", instr_pc, 32'd0);
            chk("reset_pc4", pc_plus4, 32'd0);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (cyc == 300 || cyc == 600 || (cyc >= 140 && $urandom_range(0, 199) == 0)) begin
                do_reset();
            end else begin
                drive(cyc);
                @(negedge clk);
                check_outputs();
                @(posedge clk);
                model_step();
                #1;
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
